mem_port_arbiter: RTL and testbench

//  Shares the single byte-addressed, combinational-read, level-write memory port between the

---
 rtl/mem_port_arbiter_if.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch/data requesters, mem_port_arbiter and the unified memory port.
// The arbiter takes the slave modport; the requesters and the memory take the master side.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;

    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_unsigned;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;

    logic [31:0] mem_addr;
    logic        mem_rw;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_addr, mem_rw, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_addr, mem_rw, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one word-wide memory port, with range checks,
// sub-word read-modify-write stores and load extension. Define MISALIGN_TRAP_EN to fault misaligned accesses.
module mem_port_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h0100_0000,
    parameter int unsigned MEM_BYTES = 1048576
) (
    input  logic              clock,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam logic [32:0] TOP = {1'b0, BASE_ADDR} + 33'(MEM_BYTES);

    state_t      r_state;
    state_t      w_next;
    logic        r_last_d;
    logic        r_own_d;
    logic        r_err;
    logic        r_we;
    logic        r_uns;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_word;

    logic        w_sel_d;
    logic        w_accept;
    logic        w_we;
    logic [1:0]  w_size;
    logic [31:0] w_addr;
    logic        w_misalign;
    logic        w_err;
    logic [31:0] w_aligned;

    function automatic logic range_fault(input logic [31:0] a, input logic [1:0] sz);
        logic [32:0] last;
        logic [1:0]  span;
        span = sz[1] ? 2'd3 : {1'b0, sz[0]};
        last = {1'b0, a} + {31'd0, span};
        return ({1'b0, a} < {1'b0, BASE_ADDR}) || (last >= TOP);
    endfunction

    function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] sz, input logic [1:0] a);
        logic [31:0] m;
        m = old;
        case (sz)
            2'b00:   m[{a, 3'b000} +: 8] = wd[7:0];
            2'b01:   m[{a[1], 4'b0000} +: 16] = wd[15:0];
            default: m = wd;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                             input logic [1:0] a, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{a, 3'b000} +: 8];
        h = w[{a[1], 4'b0000} +: 16];
        case (sz)
            2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // r_last_d=1 means data won last, so fetch takes the next conflict
    assign w_sel_d  = bus.d_req && (!bus.if_req || !r_last_d);
    assign w_accept = reset && (r_state == IDLE) && (bus.if_req || bus.d_req);
    assign w_we     = w_sel_d && bus.d_we;
    assign w_size   = w_sel_d ? bus.d_size : 2'b10;
    assign w_addr   = w_sel_d ? bus.d_addr : bus.if_addr;

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((w_size == 2'b01) && w_addr[0]) || (w_size[1] && (w_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err     = range_fault(w_addr, w_size) || w_misalign;
    assign w_aligned = {r_addr[31:2], 2'b00};

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_last_d <= 1'b1;
            r_own_d  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_last_d <= w_sel_d;
                r_own_d  <= w_sel_d;
                r_err    <= w_err;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_we    <= w_we;
            r_size  <= w_size;
            r_uns   <= bus.d_unsigned;
            r_addr  <= w_addr;
            r_wdata <= bus.d_wdata;
        end
        if (r_state == RD) begin
            r_word <= bus.mem_rdata;
        end
    end

    always_comb begin
        w_next        = r_state;
        bus.if_gnt    = 1'b0;
        bus.d_gnt     = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.if_rdata  = 32'd0;
        bus.if_err    = 1'b0;
        bus.d_rvalid  = 1'b0;
        bus.d_rdata   = 32'd0;
        bus.d_err     = 1'b0;
        bus.mem_addr  = 32'd0;
        bus.mem_rw    = 1'b0;
        bus.mem_wdata = 32'd0;
        case (r_state)
            IDLE: begin
                bus.if_gnt = w_accept && !w_sel_d;
                bus.d_gnt  = w_accept && w_sel_d;
                if (w_accept) begin
                    if (w_err)                   w_next = RESP;
                    else if (w_we && w_size[1])  w_next = WR;
                    else                         w_next = RD;
                end
            end
            RD: begin
                bus.mem_addr = w_aligned;
                w_next       = r_we ? WR : RESP;
            end
            WR: begin
                // reset gating keeps a write from escaping in the cycle the access is dropped
                bus.mem_addr  = w_aligned;
                bus.mem_rw    = reset;
                bus.mem_wdata = merge_store(r_word, r_wdata, r_size, r_addr[1:0]);
                w_next        = RESP;
            end
            RESP: begin
                if (r_own_d) begin
                    bus.d_rvalid = 1'b1;
                    bus.d_err    = r_err;
                    bus.d_rdata  = (r_err || r_we) ? 32'd0 : load_ext(r_word, r_size, r_addr[1:0], r_uns);
                end else begin
                    bus.if_rvalid = 1'b1;
                    bus.if_err    = r_err;
                    bus.if_rdata  = r_err ? 32'd0 : r_word;
                end
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected responses, a monitor pops and checks them.
module tb_mem_port_arbiter;
    localparam logic [31:0] BASE = 32'h0100_0000;

    typedef struct {
        logic        is_d;
        logic        err;
        logic [31:0] data;
        int          due;
        string       name;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   wr_cnt = 0;
    logic [31:0] last_wdata = 32'd0;
    logic [31:0] last_waddr = 32'd0;
    exp_t sbq[$];
    logic [31:0] mem [0:1023];

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.BASE_ADDR(BASE), .MEM_BYTES(1048576)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    assign bus.mem_rdata = mem[bus.mem_addr[11:2]];
    always @(posedge clock) if (bus.mem_rw) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // monitor: counts writes, checks grant exclusivity and pops the scoreboard on every rvalid
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (bus.mem_rw) begin
                wr_cnt++;
                last_wdata = bus.mem_wdata;
                last_waddr = bus.mem_addr;
            end
            if (bus.if_gnt || bus.d_gnt) check("gnt_exclusive", 32'(bus.if_gnt & bus.d_gnt), 32'd0);
            if (bus.if_rvalid || bus.d_rvalid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_rvalid", {30'd0, bus.if_rvalid, bus.d_rvalid}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check({e.name, "_port"}, {30'd0, bus.if_rvalid, bus.d_rvalid}, e.is_d ? 32'd1 : 32'd2);
                    check({e.name, "_rdata"}, e.is_d ? bus.d_rdata : bus.if_rdata, e.data);
                    check({e.name, "_err"}, 32'(e.is_d ? bus.d_err : bus.if_err), 32'(e.err));
                    check({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    task automatic wait_done(input string nm);
        int n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (sbq.size() != 0) begin
            check({nm, "_rvalid_timeout"}, 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
        @(posedge clock); #1;
    endtask

    task automatic data_req(input string nm, input logic we, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic eerr, input logic [31:0] edata, input int lat);
        int n = 0;
        bus.d_req = 1'b1; bus.d_we = we; bus.d_size = sz; bus.d_unsigned = uns;
        bus.d_addr = a; bus.d_wdata = wd;
        @(negedge clock);
        while (!bus.d_gnt && n < 20) begin
            n++;
            @(negedge clock);
        end
        if (!bus.d_gnt) check({nm, "_gnt_timeout"}, 32'(bus.d_gnt), 32'd1);
        else sbq.push_back('{1'b1, eerr, edata, cyc + lat, nm});
        @(posedge clock); #1;
        bus.d_req = 1'b0;
        wait_done(nm);
    endtask

    task automatic fetch_req(input string nm, input logic [31:0] a,
                             input logic eerr, input logic [31:0] edata, input int lat);
        int n = 0;
        bus.if_req = 1'b1; bus.if_addr = a;
        @(negedge clock);
        while (!bus.if_gnt && n < 20) begin
            n++;
            @(negedge clock);
        end
        if (!bus.if_gnt) check({nm, "_gnt_timeout"}, 32'(bus.if_gnt), 32'd1);
        else sbq.push_back('{1'b0, eerr, edata, cyc + lat, nm});
        @(posedge clock); #1;
        bus.if_req = 1'b0;
        wait_done(nm);
    endtask

    // both requesters held high; grants must alternate starting with fetch
    task automatic rr_seq(input string nm, input int cnt, input logic [31:0] daddr, input logic [31:0] ddata);
        bus.if_req = 1'b1; bus.if_addr = BASE;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'b10; bus.d_unsigned = 1'b1;
        bus.d_addr = daddr; bus.d_wdata = 32'd0;
        for (int k = 0; k < cnt; k++) begin
            int n;
            n = 0;
            @(negedge clock);
            while (!(bus.if_gnt || bus.d_gnt) && n < 20) begin
                n++;
                @(negedge clock);
            end
            if (k == 0) check({nm, "_first_wait"}, 32'(n), 32'd0);
            check({nm, "_order"}, {30'd0, bus.if_gnt, bus.d_gnt}, (k % 2 == 1) ? 32'd1 : 32'd2);
            if (bus.if_gnt) sbq.push_back('{1'b0, 1'b0, 32'h0BADF00D, cyc + 2, nm});
            else if (bus.d_gnt) sbq.push_back('{1'b1, 1'b0, ddata, cyc + 2, nm});
            @(posedge clock); #1;
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        wait_done(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        bus.if_req = 1'b0; bus.if_addr = 32'd0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 2'b00; bus.d_unsigned = 1'b0;
        bus.d_addr = 32'd0; bus.d_wdata = 32'd0;

        // reset with a pending fetch: everything must stay quiet
        reset = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = BASE;
        @(posedge clock); #1;
        @(negedge clock);
        check("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
        check("rst_mem_rw", 32'(bus.mem_rw), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_rvalid", {30'd0, bus.if_rvalid, bus.d_rvalid}, 32'd0);
        bus.if_req = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;

        data_req("pre0", 1, 2'b10, 0, BASE,              32'h0BADF00D, 0, 32'd0, 2);
        data_req("pre1", 1, 2'b10, 0, BASE + 32'h4,      32'h55AA1234, 0, 32'd0, 2);
        data_req("pre2", 1, 2'b10, 0, BASE + 32'hFFFFC,  32'hCAFEF00D, 0, 32'd0, 2);

        // fetch after a 2-cycle reset
        reset = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = BASE;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check("t1_gnt", 32'(bus.if_gnt), 32'd1);
        if (bus.if_gnt) sbq.push_back('{1'b0, 1'b0, 32'h0BADF00D, cyc + 2, "t1"});
        @(posedge clock); #1;
        bus.if_req = 1'b0;
        @(negedge clock);
        check("t1_mem_addr", bus.mem_addr, BASE);
        check("t1_mem_rw", 32'(bus.mem_rw), 32'd0);
        wait_done("t1");

        // word store then load
        w0 = wr_cnt;
        data_req("t2_st", 1, 2'b10, 0, BASE + 32'h10, 32'hDEADBEEF, 0, 32'd0, 2);
        check("t2_wr_pulses", 32'(wr_cnt - w0), 32'd1);
        data_req("t2_ld", 0, 2'b10, 1, BASE + 32'h10, 32'd0, 0, 32'hDEADBEEF, 2);

        // sub-word read-modify-write and load extension
        data_req("t3_st", 1, 2'b10, 0, BASE + 32'h10, 32'h11223344, 0, 32'd0, 2);
        w0 = wr_cnt;
        data_req("t3_sb", 1, 2'b00, 0, BASE + 32'h11, 32'h000000A5, 0, 32'd0, 3);
        check("t3_wr_pulses", 32'(wr_cnt - w0), 32'd1);
        check("t3_wdata", last_wdata, 32'h1122A544);
        check("t3_waddr", last_waddr, BASE + 32'h10);
        data_req("t3_lbs", 0, 2'b00, 0, BASE + 32'h11, 32'd0, 0, 32'hFFFFFFA5, 2);
        data_req("t3_lbu", 0, 2'b00, 1, BASE + 32'h11, 32'd0, 0, 32'h000000A5, 2);
        data_req("t3_lhu", 0, 2'b01, 1, BASE + 32'h12, 32'd0, 0, 32'h00001122, 2);
        data_req("t3_lhs", 0, 2'b01, 0, BASE + 32'h10, 32'd0, 0, 32'hFFFFA544, 2);
        data_req("t3_sh",  1, 2'b01, 0, BASE + 32'h12, 32'h00008001, 0, 32'd0, 3);
        data_req("t3_lw",  0, 2'b10, 0, BASE + 32'h10, 32'd0, 0, 32'h8001A544, 2);
        data_req("t3_ls3", 0, 2'b11, 1, BASE + 32'h10, 32'd0, 0, 32'h8001A544, 2);

        rr_seq("t4_rr", 3, BASE + 32'h4, 32'h55AA1234);

        // range boundaries
        w0 = wr_cnt;
        data_req("t5_lo",  1, 2'b10, 0, 32'h00FFFFFC, 32'h12345678, 1, 32'd0, 1);
        data_req("t5_hi",  1, 2'b10, 0, 32'h01100000, 32'h12345678, 1, 32'd0, 1);
        data_req("t5_hx",  1, 2'b01, 0, BASE + 32'hFFFFF, 32'h00001234, 1, 32'd0, 1);
        check("t5_no_write", 32'(wr_cnt - w0), 32'd0);
        data_req("t5_top", 0, 2'b10, 1, BASE + 32'hFFFFC, 32'd0, 0, 32'hCAFEF00D, 2);
        data_req("t5_tb",  0, 2'b00, 1, BASE + 32'hFFFFF, 32'd0, 0, 32'h000000CA, 2);
        data_req("t5_ldf", 0, 2'b10, 0, 32'h01200000, 32'd0, 1, 32'd0, 1);
        fetch_req("t5_if", 32'h00000000, 1, 32'd0, 1);

`ifdef MISALIGN_TRAP_EN
        data_req("mis_h", 0, 2'b01, 1, BASE + 32'h11, 32'd0, 1, 32'd0, 1);
        data_req("mis_w", 0, 2'b10, 0, BASE + 32'h12, 32'd0, 1, 32'd0, 1);
        fetch_req("mis_if", BASE + 32'h2, 1, 32'd0, 1);
`else
        data_req("mis_h", 0, 2'b01, 1, BASE + 32'h11, 32'd0, 0, 32'h0000A544, 2);
        data_req("mis_w", 0, 2'b10, 0, BASE + 32'h12, 32'd0, 0, 32'h8001A544, 2);
        fetch_req("mis_if", BASE + 32'h2, 0, 32'h0BADF00D, 2);
`endif

        // reset during the WR cycle of a byte store drops it
        w0 = wr_cnt;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 2'b00; bus.d_unsigned = 1'b0;
        bus.d_addr = BASE + 32'h10; bus.d_wdata = 32'h00000077;
        @(negedge clock);
        check("t6_gnt", 32'(bus.d_gnt), 32'd1);
        @(posedge clock); #1;
        bus.d_req = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("t6_mem_rw", 32'(bus.mem_rw), 32'd0);
        check("t6_rvalid", 32'(bus.d_rvalid), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        check("t6_no_write", 32'(wr_cnt - w0), 32'd0);
        rr_seq("t6_rr", 2, BASE + 32'h10, 32'h8001A544);

        // fetch wins the first conflict after reset even if fetch was granted last
        fetch_req("t7_if", BASE, 0, 32'h0BADF00D, 2);
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        rr_seq("t7_rr", 2, BASE + 32'h4, 32'h55AA1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
